// File: rtl/snn_inference_sequencer_if.sv
// Handshake and control bundle between the inference sequencer and its environment:
// the sample source, the spike generator, the accumulate layer and the result sink.
interface snn_inference_sequencer_if #(
   parameter int STEP_W    = 10,
   parameter int CLASS_W   = 5,
   parameter int SPK_CNT_W = 16
) ();

   // sample intake
   logic                 sample_valid;
   logic                 sample_ready;
   logic [STEP_W-1:0]    step_limit;

   // spike generator / accumulate layer control
   logic                 layer_clear;
   logic                 gen_start;
   logic                 step_done;
   logic                 spike_out;
   logic                 get_winner;
   logic                 infer_ready;
   logic [CLASS_W-1:0]   winner_id;

   // result channel
   logic                 result_valid;
   logic                 result_ready;
   logic [CLASS_W-1:0]   result_class;
   logic                 result_err;
   logic [SPK_CNT_W-1:0] result_spikes;

   logic                 busy;

   // sequencer side
   modport master (
      input  sample_valid, step_limit, step_done, spike_out,
             infer_ready, winner_id, result_ready,
      output sample_ready, layer_clear, gen_start, get_winner,
             result_valid, result_class, result_err, result_spikes, busy
   );

   // environment side (sample source, layers, result sink)
   modport slave (
      output sample_valid, step_limit, step_done, spike_out,
             infer_ready, winner_id, result_ready,
      input  sample_ready, layer_clear, gen_start, get_winner,
             result_valid, result_class, result_err, result_spikes, busy
   );

endinterface

// File: rtl/snn_inference_sequencer.sv
// Runs one SNN inference per accepted sample: clears the accumulate layer, starts the
// spike generator, counts timesteps up to a per-sample limit, requests the winner and
// holds the result on a valid/ready channel. A watchdog aborts stalled samples.
module snn_inference_sequencer #(
   parameter int NUM_STEPS = 1023,
   parameter int STEP_W    = 10,
   parameter int CLASS_W   = 5,
   parameter int SPK_CNT_W = 16,
   parameter int TIMEOUT   = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   snn_inference_sequencer_if.master   bus
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [STEP_W-1:0] DEFAULT_TARGET = STEP_W'(NUM_STEPS);
   // Watchdog fires on the TIMEOUT-th idle cycle, i.e. when the count already reads TIMEOUT-1.
   localparam logic [WD_W-1:0]   WD_LAST        = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_START, S_RUN, S_QUERY, S_WAIT_WIN, S_HOLD
   } state_t;

   state_t               state_q;
   logic [STEP_W-1:0]    target_q;
   logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
   logic [SPK_CNT_W-1:0] spike_cnt_q, spike_cnt_d;
   logic [WD_W-1:0]      wdog_q;

   logic                 sample_ready_q;
   logic                 layer_clear_q;
   logic                 gen_start_q;
   logic                 get_winner_q;
   logic                 result_valid_q;
   logic [CLASS_W-1:0]   result_class_q;
   logic                 result_err_q;
   logic [SPK_CNT_W-1:0] result_spikes_q;
   logic                 busy_q;

   // Step and saturating spike counters advance only while the generator is running.
   always_comb begin
      step_cnt_d  = step_cnt_q;
      spike_cnt_d = spike_cnt_q;
      if (state_q == S_RUN) begin
         if (bus.step_done)
            step_cnt_d = step_cnt_q + 1'b1;
         if (bus.spike_out && (spike_cnt_q != '1))
            spike_cnt_d = spike_cnt_q + 1'b1;
      end
   end

   // Sequencer FSM with all outputs registered alongside the state.
   // NOTE: reset is synchronous and checked first, so it overrides every other input on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         target_q        <= '0;
         step_cnt_q      <= '0;
         spike_cnt_q     <= '0;
         wdog_q          <= '0;
         sample_ready_q  <= 1'b0;
         layer_clear_q   <= 1'b0;
         gen_start_q     <= 1'b0;
         get_winner_q    <= 1'b0;
         result_valid_q  <= 1'b0;
         result_class_q  <= '0;
         result_err_q    <= 1'b0;
         result_spikes_q <= '0;
         busy_q          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; later assignments in the case override these defaults.
         step_cnt_q    <= step_cnt_d;
         spike_cnt_q   <= spike_cnt_d;
         layer_clear_q <= 1'b0;
         gen_start_q   <= 1'b0;
         get_winner_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               sample_ready_q <= 1'b1;
               if (bus.sample_valid && sample_ready_q) begin
                  target_q       <= (bus.step_limit == '0) ? DEFAULT_TARGET : bus.step_limit;
                  step_cnt_q     <= '0;
                  spike_cnt_q    <= '0;
                  wdog_q         <= '0;
                  sample_ready_q <= 1'b0;
                  layer_clear_q  <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               gen_start_q <= 1'b1;
               state_q     <= S_START;
            end

            S_START: begin
               wdog_q  <= '0;
               state_q <= S_RUN;
            end

            S_RUN: begin
               if (bus.step_done) begin
                  // a step arriving on the timeout cycle still counts and suppresses the abort
                  wdog_q <= '0;
                  if (step_cnt_d == target_q) begin
                     get_winner_q <= 1'b1;
                     state_q      <= S_QUERY;
                  end
               end else if (wdog_q == WD_LAST) begin
                  result_valid_q  <= 1'b1;
                  result_err_q    <= 1'b1;
                  result_class_q  <= '1;
                  result_spikes_q <= spike_cnt_d;
                  state_q         <= S_HOLD;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end

            S_QUERY: begin
               wdog_q  <= '0;
               state_q <= S_WAIT_WIN;
            end

            S_WAIT_WIN: begin
               if (bus.infer_ready) begin
                  result_valid_q  <= 1'b1;
                  result_err_q    <= 1'b0;
                  result_class_q  <= bus.winner_id;
                  result_spikes_q <= spike_cnt_q;
                  state_q         <= S_HOLD;
               end else if (wdog_q == WD_LAST) begin
                  result_valid_q  <= 1'b1;
                  result_err_q    <= 1'b1;
                  result_class_q  <= '1;
                  result_spikes_q <= spike_cnt_q;
                  state_q         <= S_HOLD;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end

            S_HOLD: begin
               if (bus.result_ready) begin
                  result_valid_q <= 1'b0;
                  sample_ready_q <= 1'b1;
                  busy_q         <= 1'b0;
                  state_q        <= S_IDLE;
               end
            end

            default: begin
               sample_ready_q <= 1'b0;
               result_valid_q <= 1'b0;
               busy_q         <= 1'b0;
               state_q        <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.sample_ready  = sample_ready_q;
   assign bus.layer_clear   = layer_clear_q;
   assign bus.gen_start     = gen_start_q;
   assign bus.get_winner    = get_winner_q;
   assign bus.result_valid  = result_valid_q;
   assign bus.result_class  = result_class_q;
   assign bus.result_err    = result_err_q;
   assign bus.result_spikes = result_spikes_q;
   assign bus.busy          = busy_q;

endmodule
